rsi_wilder_stream: RTL and testbench

RSI_WILDER_STREAM -- requirements
Module: rsi_wilder_stream

---
 rtl/rsi_wilder_stream.sv | 249 ++++++++++++++++++++++++
 tb/tb_rsi_wilder_stream.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rsi_wilder_stream.sv
// Streaming Wilder RSI: accumulates N price deltas, then per sample smooths gain/loss
// sums and divides them into an RSI in uq8_8 (0.00..100.00) with one shared restoring divider.
module rsi_wilder_stream #(
  parameter int N = 14,
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic [W-1:0] i_curr_price,
  input  logic         i_valid_price,
  output logic         o_ready,
  output logic [15:0]  o_rsi_scaled,
  output logic         o_rsi_valid,
  output logic         o_warm
);

  localparam int A    = W + $clog2(N);
  localparam int NUMW = A + 15;

  localparam logic [A:0]  N_DEN    = (A+1)'(N);
  localparam logic [7:0]  N_K      = 8'(N);
  localparam logic [7:0]  A_CNT    = 8'(A);
  localparam logic [14:0] RSI_FULL = 15'd25600;
  localparam logic [15:0] RSI_MID  = 16'h3200;

  typedef enum logic [2:0] {
    S_FIRST = 3'd0,
    S_WARM  = 3'd1,
    S_DIVG  = 3'd2,
    S_DIVL  = 3'd3,
    S_UPD   = 3'd4,
    S_DIVR  = 3'd5,
    S_OUT   = 3'd6
  } state_t;

  logic [1:0]      r_rst_sync;
  logic            w_rst_n;

  state_t          r_state;
  logic            r_ready;
  logic            r_warm;
  logic            r_valid;
  logic            r_ld;
  logic            r_zero;
  logic [W-1:0]    r_prev;
  logic [W-1:0]    r_gain;
  logic [W-1:0]    r_loss;
  logic [A-1:0]    r_sg;
  logic [A-1:0]    r_sl;
  logic [A-1:0]    r_qg;
  logic [A-1:0]    r_quo;
  logic [A:0]      r_rem;
  logic [A:0]      r_den;
  logic [NUMW-1:0] r_num;
  logic [7:0]      r_k;
  logic [7:0]      r_cnt;
  logic [15:0]     r_rsi;

  logic            w_accept;
  logic            w_neg;
  logic [W-1:0]    w_gain;
  logic [W-1:0]    w_loss;
  logic [A-1:0]    w_sg_acc;
  logic [A-1:0]    w_sl_acc;
  logic [A-1:0]    w_sg_upd;
  logic [A-1:0]    w_sl_upd;
  logic [A-1:0]    w_ld_g;
  logic [A-1:0]    w_ld_l;
  logic [A:0]      w_tot;
  logic [NUMW-1:0] w_numr;
  logic [A+1:0]    w_trial;
  logic            w_ge;
  logic [A:0]      w_rem_step;
  logic [A-1:0]    w_quo_step;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n  = r_rst_sync[1];
  assign w_accept = i_valid_price & r_ready;

  assign w_neg    = (i_curr_price < r_prev);
  assign w_gain   = w_neg ? {W{1'b0}} : (i_curr_price - r_prev);
  assign w_loss   = w_neg ? (r_prev - i_curr_price) : {W{1'b0}};
  assign w_sg_acc = r_sg + A'(w_gain);
  assign w_sl_acc = r_sl + A'(w_loss);

  // Sums are held as N*average, so subtracting sum/N implements Wilder smoothing.
  assign w_sg_upd = r_sg - r_qg + A'(r_gain);
  assign w_sl_upd = r_sl - r_quo + A'(r_loss);

  assign w_ld_g   = (r_state == S_UPD) ? w_sg_upd : r_sg;
  assign w_ld_l   = (r_state == S_UPD) ? w_sl_upd : r_sl;
  assign w_tot    = {1'b0, w_ld_g} + {1'b0, w_ld_l};
  assign w_numr   = NUMW'(w_ld_g) * NUMW'(RSI_FULL);

  assign w_trial    = {r_rem, r_num[NUMW-1]};
  assign w_ge       = (w_trial >= {1'b0, r_den});
  assign w_rem_step = w_ge ? (A+1)'(w_trial - {1'b0, r_den}) : w_trial[A:0];
  assign w_quo_step = {r_quo[A-2:0], w_ge};

  // Control FSM with the shared divider datapath and all registered outputs.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_FIRST;
      r_ready <= 1'b1;
      r_warm  <= 1'b0;
      r_valid <= 1'b0;
      r_ld    <= 1'b0;
      r_zero  <= 1'b0;
      r_prev  <= {W{1'b0}};
      r_gain  <= {W{1'b0}};
      r_loss  <= {W{1'b0}};
      r_sg    <= {A{1'b0}};
      r_sl    <= {A{1'b0}};
      r_qg    <= {A{1'b0}};
      r_quo   <= {A{1'b0}};
      r_rem   <= {(A+1){1'b0}};
      r_den   <= {(A+1){1'b0}};
      r_num   <= {NUMW{1'b0}};
      r_k     <= 8'd0;
      r_cnt   <= 8'd0;
      r_rsi   <= 16'h0000;
    end else if (i_clr) begin
      r_state <= S_FIRST;
      r_ready <= 1'b1;
      r_warm  <= 1'b0;
      r_valid <= 1'b0;
      r_ld    <= 1'b0;
      r_prev  <= {W{1'b0}};
      r_sg    <= {A{1'b0}};
      r_sl    <= {A{1'b0}};
      r_k     <= 8'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_FIRST: begin
          if (w_accept) begin
            r_prev  <= i_curr_price;
            r_state <= S_WARM;
          end
        end
        S_WARM: begin
          if (w_accept) begin
            r_prev <= i_curr_price;
            if (r_warm) begin
              r_gain  <= w_gain;
              r_loss  <= w_loss;
              r_rem   <= {(A+1){1'b0}};
              r_num   <= {r_sg, 15'd0};
              r_den   <= N_DEN;
              r_cnt   <= A_CNT;
              r_ready <= 1'b0;
              r_state <= S_DIVG;
            end else begin
              r_sg <= w_sg_acc;
              r_sl <= w_sl_acc;
              r_k  <= r_k + 8'd1;
              if (r_k == N_K - 8'd1) begin
                r_warm  <= 1'b1;
                r_ld    <= 1'b1;
                r_ready <= 1'b0;
                r_state <= S_DIVR;
              end
            end
          end
        end
        S_DIVG: begin
          r_quo <= w_quo_step;
          if (r_cnt == 8'd1) begin
            r_qg    <= w_quo_step;
            r_rem   <= {(A+1){1'b0}};
            r_num   <= {r_sl, 15'd0};
            r_cnt   <= A_CNT;
            r_state <= S_DIVL;
          end else begin
            r_rem <= w_rem_step;
            r_num <= {r_num[NUMW-2:0], 1'b0};
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DIVL: begin
          r_quo <= w_quo_step;
          r_rem <= w_rem_step;
          r_num <= {r_num[NUMW-2:0], 1'b0};
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_state <= S_UPD;
          end
        end
        S_UPD: begin
          r_sg    <= w_sg_upd;
          r_sl    <= w_sl_upd;
          r_rem   <= {2'b00, w_numr[NUMW-1:16]};
          r_num   <= {w_numr[15:0], {(A-1){1'b0}}};
          r_den   <= w_tot;
          r_zero  <= (w_tot == {(A+1){1'b0}});
          r_cnt   <= 8'd16;
          r_state <= S_DIVR;
        end
        S_DIVR: begin
          if (r_ld) begin
            // The Nth-delta path enters here with fresh sums and loads the divider first.
            r_rem  <= {2'b00, w_numr[NUMW-1:16]};
            r_num  <= {w_numr[15:0], {(A-1){1'b0}}};
            r_den  <= w_tot;
            r_zero <= (w_tot == {(A+1){1'b0}});
            r_cnt  <= 8'd16;
            r_ld   <= 1'b0;
          end else begin
            if (!r_zero) begin
              r_quo <= w_quo_step;
              r_rem <= w_rem_step;
              r_num <= {r_num[NUMW-2:0], 1'b0};
            end
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
              r_state <= S_OUT;
            end
          end
        end
        S_OUT: begin
          r_rsi   <= r_zero ? RSI_MID : r_quo[15:0];
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_WARM;
        end
        default: begin
          r_state <= S_FIRST;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready      = r_ready;
  assign o_rsi_scaled = r_rsi;
  assign o_rsi_valid  = r_valid;
  assign o_warm       = r_warm;

endmodule

// File: tb/tb_rsi_wilder_stream.sv
// Bench for rsi_wilder_stream (N=2, W=16): table of 3-price warm-ups plus smoothing,
// ignored-valid, clear and reset sequences, checked through a result scoreboard.
module tb_rsi_wilder_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [15:0] price;
  logic        valid;
  logic        ready;
  logic [15:0] rsi;
  logic        rsi_valid;
  logic        warm;

  typedef struct {
    logic [15:0] rsi;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] p0;
    logic [15:0] p1;
    logic [15:0] p2;
    logic [15:0] rsi;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[5];
  int          n_total = 0;
  int          n_pass  = 0;
  int          cyc     = 0;
  int          last_acc = 0;
  logic [15:0] last_rsi;
  logic        prev_v = 1'b0;

  rsi_wilder_stream #(.N(2), .W(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_clr         (clr),
    .i_curr_price  (price),
    .i_valid_price (valid),
    .o_ready       (ready),
    .o_rsi_scaled  (rsi),
    .o_rsi_valid   (rsi_valid),
    .o_warm        (warm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard side: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rsi_valid && prev_v) begin
      n_total++;
      $display("FAIL pulse_width: o_rsi_valid high for 2+ cycles at cycle %0d", cyc);
    end
    if (rsi_valid) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: got rsi=0x%0h with nothing pending", rsi);
      end else begin
        e = sb_q.pop_front();
        check("rsi_value", rsi, e.rsi);
        check("rsi_latency", cyc - e.acc, e.lat);
        check("warm_at_pulse", warm, 1);
      end
    end
    prev_v = rsi_valid;
  end

  task automatic send(input logic [15:0] p);
    int w = 0;
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      n_total++;
      $display("FAIL ready_timeout: o_ready stayed 0, price 0x%0h not sent", p);
    end else begin
      valid = 1'b1;
      price = p;
      @(negedge clk);
      valid = 1'b0;
      last_acc = cyc;
    end
  endtask

  task automatic expect_rsi(input logic [15:0] r, input int lat);
    sb_q.push_back('{rsi: r, lat: lat, acc: last_acc});
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d results still pending", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic warmup_ref();
    send(16'h0100);
    send(16'h0200);
    send(16'h0300);
    expect_rsi(16'h6400, 18);
    drain();
  endtask

  initial begin
    vecs[0] = '{16'h0100, 16'h0200, 16'h0300, 16'h6400};
    vecs[1] = '{16'h0500, 16'h0500, 16'h0500, 16'h3200};
    vecs[2] = '{16'h0300, 16'h0100, 16'h0100, 16'h0000};
    vecs[3] = '{16'h1000, 16'h0800, 16'h1800, 16'h42AA};
    vecs[4] = '{16'h0A00, 16'h0B00, 16'h0A00, 16'h3200};

    rst_n = 1'b0;
    clr   = 1'b0;
    valid = 1'b0;
    price = 16'h0000;
    #12;
    check("reset_rsi", rsi, 16'h0000);
    check("reset_valid", rsi_valid, 0);
    check("reset_warm", warm, 0);
    check("reset_ready", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    last_rsi = 16'h0000;

    for (int i = 0; i < 5; i++) begin
      do_clear();
      check("clr_warm", warm, 0);
      check("clr_retain_rsi", rsi, last_rsi);
      send(vecs[i].p0);
      send(vecs[i].p1);
      check("warm_before_n", warm, 0);
      send(vecs[i].p2);
      expect_rsi(vecs[i].rsi, 18);
      check("ready_low_div", ready, 0);
      check("warm_after_n", warm, 1);
      drain();
      last_rsi = vecs[i].rsi;
    end

    // Smoothing step from Sg=Sl=0x100 with a price held valid while busy.
    send(16'h0C00);
    expect_rsi(16'h5355, 52);
    valid = 1'b1;
    price = 16'hFF00;
    repeat (30) @(negedge clk);
    check("ready_low_hold", ready, 0);
    valid = 1'b0;
    drain();
    repeat (60) @(negedge clk);
    send(16'h0D00);
    expect_rsi(16'h5A00, 52);
    drain();

    // Clear during DIVL aborts the result and restarts warm-up.
    do_clear();
    warmup_ref();
    send(16'h0400);
    repeat (25) @(negedge clk);
    do_clear();
    check("clr_div_warm", warm, 0);
    check("clr_div_ready", ready, 1);
    check("clr_div_retain", rsi, 16'h6400);
    repeat (60) @(negedge clk);
    warmup_ref();

    // Reset during DIVL behaves likewise but also zeroes the output.
    send(16'h0400);
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_div_rsi", rsi, 16'h0000);
    check("rst_div_warm", warm, 0);
    check("rst_div_ready", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    warmup_ref();

    check("queue_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
